// File: rtl/light_driver.sv
// light_driver: turn-signal / lamp animation driver.
//
// The asynchronous light-mode code is synchronised and then debounced. A new
// code becomes the active mode only after it has held steady for STABLE
// cycles. A prescaler divides the clock into animation steps, and each step
// advances a 2-bit phase. The lamp outputs are a registered decode of
// (mode, phase).
//
// Ports
//   clk_1m  in   1  system clock (1 MHz), rising edge
//   rst_n   in   1  asynchronous active-low reset
//   state   in   3  requested light-mode code (asynchronous)
//   led_l   out  3  left lamps, bit0 inner .. bit2 outer, 1 = lit
//   led_r   out  3  right lamps, bit2 inner .. bit0 outer, 1 = lit
//   mode    out  3  accepted (filtered) mode code
//   phase   out  2  animation phase 0..3
module light_driver #(
  parameter int STEP_DIV = 250000,
  parameter int STABLE   = 4
) (
  input  logic       clk_1m,
  input  logic       rst_n,
  input  logic [2:0] state,
  output logic [2:0] led_l,
  output logic [2:0] led_r,
  output logic [2:0] mode,
  output logic [1:0] phase
);

  localparam logic [2:0] CODE_RIGHT = 3'b000;
  localparam logic [2:0] CODE_FWD   = 3'b001;
  localparam logic [2:0] CODE_BACK  = 3'b010;
  localparam logic [2:0] CODE_LEFT  = 3'b011;
  localparam logic [2:0] CODE_ALL   = 3'b111;

  localparam int              PW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [3:0]      STABLE_C = 4'(STABLE);

  logic [2:0]    s1_q, s2_q;
  logic [2:0]    sync_code;
  logic [2:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    led_l_q, led_l_d;
  logic [2:0]    led_r_q, led_r_d;

  // Unused codes 100/101/110 all collapse onto all-on.
  assign sync_code = s2_q[2] ? CODE_ALL : s2_q;

  // Stability filter
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (sync_code == mode_q) begin
      cnt_d = 4'd0;
    end else begin
      if (sync_code == cand_q) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = sync_code;
        cnt_d  = 4'd1;
      end
      if (cnt_d == STABLE_C) begin
        mode_d = cand_d;
        cnt_d  = 4'd0;
      end
    end
  end

  // Animation timebase; a mode change restarts the sequence from phase 0.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if (mode_d != mode_q) begin
      presc_d = '0;
      phase_d = 2'd0;
    end else if (presc_q == PRE_LAST) begin
      presc_d = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Lamp decode from the currently registered mode/phase.
  always_comb begin
    led_l_d = 3'b000;
    led_r_d = 3'b000;
    case (mode_q)
      CODE_LEFT: begin
        case (phase_q)
          2'd0:    led_l_d = 3'b001;
          2'd1:    led_l_d = 3'b011;
          2'd2:    led_l_d = 3'b111;
          default: led_l_d = 3'b000;
        endcase
      end
      CODE_RIGHT: begin
        case (phase_q)
          2'd0:    led_r_d = 3'b100;
          2'd1:    led_r_d = 3'b110;
          2'd2:    led_r_d = 3'b111;
          default: led_r_d = 3'b000;
        endcase
      end
      CODE_FWD: begin
        led_l_d = 3'b010;
        led_r_d = 3'b010;
      end
      CODE_BACK: begin
        if (!phase_q[1]) begin
          led_l_d = 3'b111;
          led_r_d = 3'b111;
        end
      end
      default: begin
        led_l_d = 3'b111;
        led_r_d = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= CODE_ALL;
      s2_q    <= CODE_ALL;
      cand_q  <= CODE_ALL;
      cnt_q   <= 4'd0;
      mode_q  <= CODE_ALL;
      presc_q <= '0;
      phase_q <= 2'd0;
      led_l_q <= 3'b000;
      led_r_q <= 3'b000;
    end else begin
      s1_q    <= state;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      led_l_q <= led_l_d;
      led_r_q <= led_r_d;
    end
  end

  assign led_l = led_l_q;
  assign led_r = led_r_q;
  assign mode  = mode_q;
  assign phase = phase_q;

endmodule

// File: doc/light_driver.md
LIGHT_DRIVER -- requirements
Module: light_driver

Interface
REQ-001 Parameter STEP_DIV, default 250000: clk_1m cycles per animation step (250 ms); legal range 2..2^20.
REQ-002 Parameter STABLE, default 4: consecutive cycles a new code SHALL hold before acceptance; legal range 2..15.
REQ-003 clk_1m  input  1  system clock, 1 MHz; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 state  input  3  light-mode code from the direction-transfer stage, asynchronous to this block.
REQ-006 led_l  output  3  left lamp group; bit0 inner, bit2 outer; 1 = lit.
REQ-007 led_r  output  3  right lamp group; bit2 inner, bit0 outer; 1 = lit.
REQ-008 mode  output  3  currently accepted code after filtering.
REQ-009 phase  output  2  current animation phase, 0..3.

Function
REQ-010 Code map: 000 right turn, 011 left turn, 001 forward, 010 backward, 111 all-on; codes 100/101/110 SHALL be treated as 111 at the synchroniser output.
REQ-011 state SHALL pass a 2-flop synchroniser (s1, s2) before any use.
REQ-012 Filter: when s2 differs from mode, a candidate register and a 4-bit count SHALL track it; same candidate -> count+1; new candidate -> candidate = s2, count = 1; s2 equal to mode -> count = 0.
REQ-013 mode SHALL load the candidate on the edge where count reaches STABLE; count clears on that edge.
REQ-014 Latency: with STABLE=4, an input change captured at edge 1 SHALL appear on mode at edge 6 and on led_l/led_r at edge 7.
REQ-015 Prescaler counts 0..STEP_DIV-1 and wraps; on wrap, phase increments modulo 4 (3 -> 0).
REQ-016 On the edge mode changes, prescaler and phase SHALL both clear to 0.
REQ-017 led_l/led_r SHALL be registered, decoded from (mode, phase) with one cycle of latency.
REQ-018 Left (011): led_l = 001, 011, 111, 000 for phase 0..3; led_r = 000.
REQ-019 Right (000): led_r = 100, 110, 111, 000 for phase 0..3; led_l = 000.
REQ-020 Forward (001): led_l = led_r = 010, independent of phase.
REQ-021 Backward (010): all six lamps lit in phases 0-1 and dark in phases 2-3.
REQ-022 All-on (111): all six lamps lit, independent of phase.
REQ-023 Oscillating input never stable for STABLE cycles SHALL leave mode, phase and lamps unaffected; phase continues to advance.

Reset
REQ-024 rst_n low SHALL immediately force led_l = led_r = 000, mode = 111, phase = 0, prescaler = 0, count = 0, candidate = 111, s1 = s2 = 111.
REQ-025 Reset mid-animation or mid-filter SHALL discard all progress; no partial sequence SHALL resume.
REQ-026 After rst_n rises, the first rising edge SHALL drive all six lamps lit (mode 111).

Verification (STEP_DIV=4, STABLE=4)
REQ-027 Reset then state=111 -> lamps 000 during reset; 111/111 from the first edge after release; mode=111.
REQ-028 state 111->011 held -> led_l=001 at edge 7 after the change, 011 at +4, 111 at +8, 000 at +12, 001 at +16; led_r=000 throughout.
REQ-029 state 111->000 for 3 cycles, then 111 -> mode remains 111; lamps stay 111/111; phase sequence unbroken.
REQ-030 state=010 held -> all lamps lit for 8 edges, dark for 8 edges, repeating; phase changes to 0 on acceptance.
REQ-031 In left mode at phase 2, pulse rst_n low -> lamps 000 asynchronously, before the next edge; after release -> 111/111, phase=0.
REQ-032 From mode 011, state=101 held -> mode=111 after STABLE filtering; all lamps lit; 101 never appears on mode.
